// File: rtl/icache_miss_ctrl.sv
// Instruction-cache miss handler: stalls fetch on a lookup miss, requests the
// whole line from memory, assembles the returned beats, writes the line into
// the cache and replays the critical word to fetch.
module icache_miss_ctrl #(
   parameter int ADDR_W     = 32,
   parameter int DATA_W     = 32,
   parameter int LINE_WORDS = 4
) (
   input  logic                         CLK,
   input  logic                         RESET,
   input  logic                         req_valid_i,
   input  logic [ADDR_W-1:0]            req_addr_i,
   input  logic                         hit_i,
   input  logic [DATA_W-1:0]            hit_data_i,
   output logic                         resp_valid,
   output logic [DATA_W-1:0]            resp_data,
   output logic                         stall,
   output logic                         mem_req_valid,
   output logic [ADDR_W-1:0]            mem_req_addr,
   input  logic                         mem_req_ready,
   input  logic                         mem_rdata_valid,
   input  logic [DATA_W-1:0]            mem_rdata,
   output logic                         fill_valid,
   output logic [ADDR_W-1:0]            fill_addr,
   output logic [LINE_WORDS*DATA_W-1:0] fill_line,
   output logic                         busy
);

   localparam int OFF_W = $clog2(LINE_WORDS);
   localparam int LSB   = OFF_W + 2;

   typedef enum logic [2:0] {
      IDLE,
      REQ,
      FILL,
      WRITE,
      REPLAY
   } state_t;

   state_t                         state;
   logic [ADDR_W-1:0]              miss_addr;
   logic [OFF_W-1:0]               beat_cnt;
   logic [LINE_WORDS*DATA_W-1:0]   line_buf;
   logic [ADDR_W-1:0]              line_addr;
   logic [OFF_W-1:0]               replay_off;
   logic                           last_beat;

   assign line_addr  = {miss_addr[ADDR_W-1:LSB], {LSB{1'b0}}};
   assign replay_off = miss_addr[LSB-1:2];
   assign last_beat  = (beat_cnt == OFF_W'(LINE_WORDS - 1));

   // Refill sequencer: capture the miss, handshake the request, collect beats.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         state     <= IDLE;
         miss_addr <= '0;
         beat_cnt  <= '0;
         // NOTE: the line buffer is a plain register bank that drives fill_line,
         // so it is cleared on reset like any other state rather than left as
         // an unreset memory.
         line_buf  <= '0;
      end else begin
         // NOTE: non-blocking assignments keep every register updating from the
         // values of the previous cycle, independent of statement order.
         case (state)
            IDLE: begin
               if (req_valid_i && !hit_i) begin
                  miss_addr <= req_addr_i;
                  state     <= REQ;
               end
            end
            REQ: begin
               if (mem_req_ready) begin
                  beat_cnt <= '0;
                  state    <= FILL;
               end
            end
            FILL: begin
               if (mem_rdata_valid) begin
                  line_buf[int'(beat_cnt)*DATA_W +: DATA_W] <= mem_rdata;
                  beat_cnt <= beat_cnt + OFF_W'(1);
                  if (last_beat) state <= WRITE;
               end
            end
            WRITE:   state <= REPLAY;
            REPLAY:  state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   // Output decode from the registered state; hit/miss response in IDLE is same-cycle.
   always_comb begin
      // NOTE: every output gets a default first so no path through the case
      // leaves one unassigned and infers a latch.
      resp_valid    = 1'b0;
      resp_data     = '0;
      stall         = 1'b0;
      mem_req_valid = 1'b0;
      mem_req_addr  = '0;
      fill_valid    = 1'b0;
      fill_addr     = '0;
      fill_line     = '0;
      busy          = (state != IDLE);
      case (state)
         IDLE: begin
            if (req_valid_i) begin
               if (hit_i) begin
                  resp_valid = 1'b1;
                  resp_data  = hit_data_i;
               end else begin
                  stall = 1'b1;
               end
            end
         end
         REQ: begin
            mem_req_valid = 1'b1;
            mem_req_addr  = line_addr;
            stall         = 1'b1;
         end
         FILL: stall = 1'b1;
         WRITE: begin
            stall      = 1'b1;
            fill_valid = 1'b1;
            fill_addr  = line_addr;
            fill_line  = line_buf;
         end
         REPLAY: begin
            resp_valid = 1'b1;
            resp_data  = line_buf[int'(replay_off)*DATA_W +: DATA_W];
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_icache_miss_ctrl.sv
// Bench for icache_miss_ctrl: transaction-level model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_icache_miss_ctrl;

   logic          CLK = 1'b0;
   logic          RESET;
   logic          req_valid_i;
   logic [31:0]   req_addr_i;
   logic          hit_i;
   logic [31:0]   hit_data_i;
   logic          resp_valid;
   logic [31:0]   resp_data;
   logic          stall;
   logic          mem_req_valid;
   logic [31:0]   mem_req_addr;
   logic          mem_req_ready;
   logic          mem_rdata_valid;
   logic [31:0]   mem_rdata;
   logic          fill_valid;
   logic [31:0]   fill_addr;
   logic [127:0]  fill_line;
   logic          busy;

   icache_miss_ctrl #(.ADDR_W(32), .DATA_W(32), .LINE_WORDS(4)) dut (
      .CLK(CLK), .RESET(RESET),
      .req_valid_i(req_valid_i), .req_addr_i(req_addr_i),
      .hit_i(hit_i), .hit_data_i(hit_data_i),
      .resp_valid(resp_valid), .resp_data(resp_data), .stall(stall),
      .mem_req_valid(mem_req_valid), .mem_req_addr(mem_req_addr),
      .mem_req_ready(mem_req_ready),
      .mem_rdata_valid(mem_rdata_valid), .mem_rdata(mem_rdata),
      .fill_valid(fill_valid), .fill_addr(fill_addr), .fill_line(fill_line),
      .busy(busy)
   );

   always #5 CLK = ~CLK;

   int tests = 0;
   int fails = 0;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, want %0h", name, act, exp);
      end
   endtask

   // Model: a miss is a transaction that owns the controller until its replay.
   bit           cmp_en = 1'b0;
   bit           m_busy, m_acc, m_wrote;
   logic [31:0]  m_addr;
   logic [31:0]  m_words[$];

   always @(posedge CLK) begin
      if (RESET) begin
         m_busy = 0; m_acc = 0; m_wrote = 0; m_addr = '0;
         m_words.delete();
      end else if (!m_busy) begin
         if (req_valid_i && !hit_i) begin
            m_busy = 1; m_acc = 0; m_wrote = 0; m_addr = req_addr_i;
            m_words.delete();
         end
      end else if (!m_acc) begin
         if (mem_req_ready) m_acc = 1;
      end else if (m_words.size() < 4) begin
         if (mem_rdata_valid) m_words.push_back(mem_rdata);
      end else if (!m_wrote) begin
         m_wrote = 1;
      end else begin
         m_busy = 0;
      end
   end

   // Observation statistics, written only by the compare process.
   int            n_req = 0, n_fill = 0, n_resp = 0;
   logic [31:0]   last_req_addr, last_fill_addr, last_resp_data;
   logic [127:0]  last_fill_line;

   logic          e_rv, e_stall, e_mrv, e_fv, e_busy;
   logic [31:0]   e_rd, e_mra, e_fa;
   logic [127:0]  e_fl;

   always @(negedge CLK) begin
      if (cmp_en) begin
         e_rv = 0; e_rd = '0; e_stall = 0; e_mrv = 0; e_mra = '0;
         e_fv = 0; e_fa = '0; e_fl = '0; e_busy = m_busy;
         if (!m_busy) begin
            if (req_valid_i && hit_i) begin e_rv = 1; e_rd = hit_data_i; end
            e_stall = req_valid_i && !hit_i;
         end else if (!m_acc) begin
            e_mrv = 1; e_mra = {m_addr[31:4], 4'h0}; e_stall = 1;
         end else if (m_words.size() < 4) begin
            e_stall = 1;
         end else if (!m_wrote) begin
            e_fv = 1; e_fa = {m_addr[31:4], 4'h0}; e_stall = 1;
            for (int i = 0; i < 4; i++) e_fl[i*32 +: 32] = m_words[i];
         end else begin
            e_rv = 1; e_rd = m_words[m_addr[3:2]];
         end
         check("resp_valid", resp_valid, e_rv);
         check("resp_data", resp_data, e_rd);
         check("stall", stall, e_stall);
         check("mem_req_valid", mem_req_valid, e_mrv);
         check("mem_req_addr", mem_req_addr, e_mra);
         check("fill_valid", fill_valid, e_fv);
         check("fill_addr", fill_addr, e_fa);
         check("fill_line", fill_line, e_fl);
         check("busy", busy, e_busy);
         check("resp_fill_excl", resp_valid & fill_valid, 1'b0);
         if (mem_req_valid) begin n_req++; last_req_addr = mem_req_addr; end
         if (fill_valid) begin n_fill++; last_fill_addr = fill_addr; last_fill_line = fill_line; end
         if (resp_valid) begin n_resp++; last_resp_data = resp_data; end
      end
   end

   logic [31:0] beat_q [4];

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic lookup_noise(input bit noisy);
      req_valid_i = noisy ? 1'($urandom) : 1'b0;
      hit_i       = 1'($urandom);
      req_addr_i  = $urandom;
      hit_data_i  = $urandom;
   endtask

   // Entered and left at posedge+1 with the controller in IDLE.
   task automatic do_miss(input logic [31:0] addr, input int rdy_dly, input int gap, input bit noisy);
      req_valid_i = 1; hit_i = 0; req_addr_i = addr; hit_data_i = $urandom;
      mem_req_ready = 0; mem_rdata_valid = 0;
      tick();
      for (int i = 0; i < rdy_dly; i++) begin
         lookup_noise(noisy);
         mem_req_ready = 0;
         mem_rdata_valid = noisy ? 1'($urandom) : 1'b0;
         mem_rdata = $urandom;
         tick();
      end
      lookup_noise(noisy);
      mem_req_ready = 1; mem_rdata_valid = 0;
      tick();
      mem_req_ready = 0;
      for (int b = 0; b < 4; b++) begin
         for (int g = 0; g < gap; g++) begin
            lookup_noise(noisy);
            mem_rdata_valid = 0; mem_rdata = $urandom;
            mem_req_ready = noisy ? 1'($urandom) : 1'b0;
            tick();
         end
         lookup_noise(noisy);
         mem_rdata_valid = 1; mem_rdata = beat_q[b];
         tick();
      end
      mem_rdata_valid = 0; mem_req_ready = 0;
      lookup_noise(noisy);
      tick();
      lookup_noise(noisy);
      tick();
      req_valid_i = 0; hit_i = 0;
   endtask

   int s_req, s_fill, s_resp;

   task automatic snap();
      s_req = n_req; s_fill = n_fill; s_resp = n_resp;
   endtask

   initial begin
      RESET = 1; req_valid_i = 0; req_addr_i = '0; hit_i = 0; hit_data_i = '0;
      mem_req_ready = 0; mem_rdata_valid = 0; mem_rdata = '0;
      tick();
      cmp_en = 1;
      tick();
      RESET = 0;
      #1;
      check("rst_busy", busy, 1'b0);
      check("rst_stall", stall, 1'b0);
      check("rst_fill_line", fill_line, 128'h0);
      check("rst_mem_req_valid", mem_req_valid, 1'b0);
      tick();

      // Hit served in the same cycle.
      req_valid_i = 1; hit_i = 1; hit_data_i = 32'h0000_0013;
      #1;
      check("hit_resp_valid", resp_valid, 1'b1);
      check("hit_resp_data", resp_data, 32'h0000_0013);
      check("hit_stall", stall, 1'b0);
      check("hit_no_req", mem_req_valid, 1'b0);
      tick();
      req_valid_i = 0; hit_i = 0;
      tick();

      // Miss with immediate ready and back-to-back beats.
      beat_q = '{32'hA0, 32'hA1, 32'hA2, 32'hA3};
      snap();
      do_miss(32'h0000_1008, 0, 0, 0);
      check("imm_req_cycles", n_req - s_req, 1);
      check("imm_req_addr", last_req_addr, 32'h0000_1000);
      check("imm_fill_cnt", n_fill - s_fill, 1);
      check("imm_fill_addr", last_fill_addr, 32'h0000_1000);
      check("imm_fill_line", last_fill_line, 128'h000000A3_000000A2_000000A1_000000A0);
      check("imm_replay", last_resp_data, 32'h0000_00A2);

      // Backpressure on the request and gapped beats.
      beat_q = '{32'h1111_0000, 32'h1111_0001, 32'h1111_0002, 32'h1111_0003};
      snap();
      do_miss(32'h0000_3004, 5, 2, 0);
      check("bp_req_cycles", n_req - s_req, 6);
      check("bp_fill_cnt", n_fill - s_fill, 1);
      check("bp_replay", last_resp_data, 32'h1111_0001);

      // Offset selection and address-space wrap.
      beat_q = '{32'hB0, 32'hB1, 32'hB2, 32'hB3};
      do_miss(32'h0000_200C, 1, 1, 0);
      check("off3_replay", last_resp_data, 32'h0000_00B3);
      check("off3_fill_addr", last_fill_addr, 32'h0000_2000);
      beat_q = '{32'hC0, 32'hC1, 32'hC2, 32'hC3};
      do_miss(32'hFFFF_FFF0, 0, 0, 0);
      check("top_req_addr", last_req_addr, 32'hFFFF_FFF0);
      check("top_replay", last_resp_data, 32'h0000_00C0);

      // Lookup traffic while busy is ignored.
      beat_q = '{32'hD0, 32'hD1, 32'hD2, 32'hD3};
      snap();
      do_miss(32'h0000_5008, 3, 2, 1);
      check("busy_req_cycles", n_req - s_req, 4);
      check("busy_resp_cnt", n_resp - s_resp, 1);
      check("busy_replay", last_resp_data, 32'h0000_00D2);

      // Reset in the middle of the fill.
      req_valid_i = 1; hit_i = 0; req_addr_i = 32'h0000_4004;
      tick();
      req_valid_i = 0; mem_req_ready = 1;
      tick();
      mem_req_ready = 0;
      for (int b = 0; b < 2; b++) begin
         mem_rdata_valid = 1; mem_rdata = 32'hE0 + b;
         tick();
      end
      mem_rdata_valid = 0; RESET = 1;
      tick();
      RESET = 0;
      #1;
      check("mid_rst_busy", busy, 1'b0);
      check("mid_rst_stall", stall, 1'b0);
      check("mid_rst_fill_valid", fill_valid, 1'b0);
      check("mid_rst_fill_line", fill_line, 128'h0);
      check("mid_rst_resp_valid", resp_valid, 1'b0);
      snap();
      tick();
      for (int b = 0; b < 2; b++) begin
         mem_rdata_valid = 1; mem_rdata = 32'hE2 + b;
         tick();
      end
      mem_rdata_valid = 0;
      tick();
      tick();
      check("mid_rst_no_fill", n_fill - s_fill, 0);
      check("mid_rst_no_req", n_req - s_req, 0);
      req_valid_i = 1; hit_i = 1; hit_data_i = 32'hDEAD_BEEF;
      #1;
      check("post_rst_hit", resp_data, 32'hDEAD_BEEF);
      tick();
      req_valid_i = 0; hit_i = 0;

      // Randomized traffic checked by the model.
      for (int n = 0; n < 60; n++) begin
         case ($urandom % 3)
            0: begin
               req_valid_i = 0; hit_i = 1'($urandom);
               mem_rdata_valid = 1'($urandom); mem_rdata = $urandom;
               mem_req_ready = 1'($urandom);
               tick();
               mem_rdata_valid = 0; mem_req_ready = 0;
            end
            1: begin
               req_valid_i = 1; hit_i = 1; hit_data_i = $urandom; req_addr_i = $urandom;
               tick();
               req_valid_i = 0;
            end
            default: begin
               for (int b = 0; b < 4; b++) beat_q[b] = $urandom;
               do_miss($urandom, int'($urandom % 4), int'($urandom % 3), 1'($urandom));
            end
         endcase
      end
      tick();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/icache_miss_ctrl.md
Name: icache_miss_ctrl

Overview:
Miss handler and refill sequencer for the instruction-cache lookup pipeline register stage. It watches the registered lookup result (request valid, hit, address). On a miss it stalls the fetch pipe, fetches the full line from memory over a valid/ready request and beat-return interface, and writes the assembled line into the cache. It then replays the stalled address and returns the critical word.

Parameters:
ADDR_W, 32, byte address width
DATA_W, 32, instruction word and memory beat width
LINE_WORDS, 4, words per cache line (power of two, >=2)

Ports:
CLK  input  1  clock, all state updates on rising edge
RESET  input  1  synchronous active-high reset
req_valid_i  input  1  registered lookup valid (pipeline register request_valid)
req_addr_i  input  ADDR_W  registered lookup address
hit_i  input  1  registered lookup hit
hit_data_i  input  DATA_W  registered hit data
resp_valid  output  1  instruction word valid to fetch
resp_data  output  DATA_W  instruction word
stall  output  1  freeze fetch PC and lookup pipeline register
mem_req_valid  output  1  line read request
mem_req_addr  output  ADDR_W  line-aligned request address
mem_req_ready  input  1  memory accepts request
mem_rdata_valid  input  1  return beat valid
mem_rdata  input  DATA_W  return beat, ascending word order from offset 0
fill_valid  output  1  one-cycle cache line write strobe
fill_addr  output  ADDR_W  line-aligned fill address
fill_line  output  LINE_WORDS*DATA_W  assembled line; word i at bits [i*DATA_W +: DATA_W]
busy  output  1  controller not IDLE

Behaviour:
- Interface: one clock CLK; RESET is synchronous and active-high.
- Reset, on a sampled rising edge with RESET=1: state=IDLE. All outputs 0, including fill_line, the beat counter and the captured address. Reset applied mid-refill abandons the refill. Memory beats arriving afterwards are ignored.
- Word offset: OFF = req_addr[log2(LINE_WORDS)+1:2]. Line address = addr with the low log2(LINE_WORDS)+2 bits cleared.
- States: IDLE, REQ, FILL, WRITE, REPLAY.
- IDLE, req_valid_i & hit_i: resp_valid=1 and resp_data=hit_data_i, combinationally in the same cycle. stall=0.
- IDLE, req_valid_i & !hit_i:
  - resp_valid=0 and stall=1 combinationally.
  - Capture addr. Next state REQ.
- IDLE, !req_valid_i: outputs idle.
- REQ:
  - mem_req_valid=1, mem_req_addr = captured line address. These hold stable until handshake.
  - On mem_req_valid & mem_req_ready: clear the beat counter, then go to FILL.
- FILL:
  - Each mem_rdata_valid writes word[cnt] of the line buffer, then cnt++.
  - When the last beat (cnt==LINE_WORDS-1) is accepted, go to WRITE.
  - Beats before the handshake completes are ignored. The memory returns no beats until the cycle after acceptance.
- WRITE: fill_valid=1 for exactly 1 cycle, with fill_addr = line address and fill_line = buffer. Next state REPLAY.
- REPLAY:
  - resp_valid=1 and resp_data = buffer word[OFF] for exactly 1 cycle; stall=0 in that cycle.
  - Next state IDLE.
  - The lookup register contents in this cycle are ignored (stale). The pipeline releases the next fetch from here.
- stall=1 in REQ, FILL and WRITE, and in the IDLE miss cycle. stall=0 otherwise.
- busy=1 in every state except IDLE.
- No second miss is accepted until IDLE.
- mem_req_addr/fill_addr are line-aligned and never carry offset bits.
- Miss latency: the miss cycle, plus at least 1 REQ cycle, plus LINE_WORDS beats plus gaps, plus WRITE, plus REPLAY.
- resp_valid and fill_valid are never high in the same cycle.

Test Plan:
- Hit: req_valid_i=1, hit_i=1, hit_data_i=0x00000013 in IDLE -> same-cycle resp_valid=1, resp_data=0x00000013, stall=0, no mem_req_valid.
- Miss with immediate ready:
  - Stimulus: addr 0x00001008, LINE_WORDS=4; mem_req_ready=1; beats 0xA0,0xA1,0xA2,0xA3 back-to-back.
  - Required: mem_req_addr=0x00001000 for 1 cycle.
  - Required: fill_valid with fill_addr=0x00001000 and fill_line words {A0,A1,A2,A3}.
  - Required: next cycle resp_data=0xA2, resp_valid=1, stall=0 on that cycle.
- Backpressure and gaps: mem_req_ready held 0 for 5 cycles, then beats arrive with 2-cycle gaps -> mem_req_valid/addr stable for all 5 cycles; stall stays 1; counter advances only on valid beats; fill occurs after the 4th beat.
- Offset/wrap: miss at 0x0000200C -> replayed word = beat 3. Miss at 0xFFFFFFF0 -> line addr 0xFFFFFFF0, replayed word = beat 0.
- Reset mid-FILL: RESET=1 after 2 beats -> next cycle all outputs 0, state IDLE. Leftover beats then cause no fill_valid. A new hit is served normally.
- Ignore while busy: req_valid_i toggles with hit/miss during FILL -> no extra mem_req_valid, and resp_valid only in the REPLAY cycle.
